// File: rtl/fp_align_stage_pkg.sv
// Shared definitions for the floating-point add/sub datapath: field widths,
// the far-alignment limit and the aligned-operand bundle handed to the adder.
package fp_align_stage_pkg;

   localparam int EXP_W     = 8;
   localparam int MANT_W    = 24;
   localparam int SHIFT_W   = 5;
   localparam int FAR_LIMIT = 24;

   typedef struct packed {
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant_big;
      logic [MANT_W-1:0] mant_small;
      logic [2:0]        grs;
      logic              swapped;
   } align_bundle_t;

   // The comparator zeroes its shift count once the gap reaches the significand
   // width, so the far case has to be rediscovered from the exponents themselves.
   function automatic logic is_far(input logic [EXP_W-1:0] exp_big,
                                   input logic [EXP_W-1:0] exp_small);
      logic [EXP_W:0] diff;
      diff = {1'b0, exp_big} - {1'b0, exp_small};
      return diff >= (EXP_W + 1)'(FAR_LIMIT);
   endfunction

endpackage

// File: rtl/fp_sticky_shift.sv
// Combinational right shifter for the smaller significand that also collects
// the guard, round and sticky bits lost off the bottom.
module fp_sticky_shift #(
   parameter int MANT_W  = 24,
   parameter int SHIFT_W = 5
) (
   input  logic [MANT_W-1:0]  mant_in,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               far,
   output logic [MANT_W-1:0]  shifted,
   output logic [2:0]         grs
);

   localparam int PAD_W = 1 << SHIFT_W;
   localparam int EXT_W = MANT_W + PAD_W;

   logic [EXT_W-1:0] ext;

   // Padding by the full shift range keeps every bit that falls off the
   // significand inside the extension, so sticky never loses a set bit.
   always_comb begin
      ext     = {mant_in, {PAD_W{1'b0}}} >> shift;
      shifted = ext[EXT_W-1:PAD_W];
      grs     = {ext[PAD_W-1], ext[PAD_W-2], |ext[PAD_W-3:0]};
      if (far) begin
         shifted = '0;
         grs     = {2'b00, |mant_in};
      end
   end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage mantissa alignment: stage 1 orders the operands by exponent,
// stage 2 shifts the smaller significand and produces guard/round/sticky.
module fp_align_stage #(
   parameter int MANT_W  = fp_align_stage_pkg::MANT_W,
   parameter int SHIFT_W = fp_align_stage_pkg::SHIFT_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [fp_align_stage_pkg::EXP_W-1:0] exp_a,
   input  logic [fp_align_stage_pkg::EXP_W-1:0] exp_b,
   input  logic [MANT_W-1:0]                   mant_a,
   input  logic [MANT_W-1:0]                   mant_b,
   input  logic [SHIFT_W-1:0]                  numbershift,
   input  logic                                sign,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [fp_align_stage_pkg::EXP_W-1:0] exp_out,
   output logic [MANT_W-1:0]                   mant_big,
   output logic [MANT_W-1:0]                   mant_small,
   output logic [2:0]                          grs,
   output logic                                swapped
);

   import fp_align_stage_pkg::*;

   logic                s1_valid;
   logic [EXP_W-1:0]    s1_exp;
   logic [MANT_W-1:0]   s1_big;
   logic [MANT_W-1:0]   s1_small;
   logic [SHIFT_W-1:0]  s1_shift;
   logic                s1_far;
   logic                s1_swapped;

   logic                s1_advance;
   logic                accept;

   logic [EXP_W-1:0]    sel_exp_big;
   logic [EXP_W-1:0]    sel_exp_small;
   logic [MANT_W-1:0]   sel_big;
   logic [MANT_W-1:0]   sel_small;

   logic [MANT_W-1:0]   sh_mant;
   logic [2:0]          sh_grs;

   // Stage 2 frees up when empty or draining; in_ready never looks at in_valid.
   assign s1_advance = ~out_valid | out_ready;
   assign in_ready   = ~rst & (~s1_valid | s1_advance);
   assign accept     = in_valid & in_ready;

   always_comb begin
      sel_exp_big   = exp_a;
      sel_exp_small = exp_b;
      sel_big       = mant_a;
      sel_small     = mant_b;
      if (sign) begin
         sel_exp_big   = exp_b;
         sel_exp_small = exp_a;
         sel_big       = mant_b;
         sel_small     = mant_a;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_exp     <= '0;
         s1_big     <= '0;
         s1_small   <= '0;
         s1_shift   <= '0;
         s1_far     <= 1'b0;
         s1_swapped <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (accept) begin
            s1_exp     <= sel_exp_big;
            s1_big     <= sel_big;
            s1_small   <= sel_small;
            s1_shift   <= numbershift;
            s1_far     <= is_far(sel_exp_big, sel_exp_small);
            s1_swapped <= sign;
         end
      end
   end

   fp_sticky_shift #(
      .MANT_W  (MANT_W),
      .SHIFT_W (SHIFT_W)
   ) u_sticky_shift (
      .mant_in (s1_small),
      .shift   (s1_shift),
      .far     (s1_far),
      .shifted (sh_mant),
      .grs     (sh_grs)
   );

   // Output registers only change on a transfer, which keeps them frozen
   // for the whole of a downstream stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         exp_out    <= '0;
         mant_big   <= '0;
         mant_small <= '0;
         grs        <= '0;
         swapped    <= 1'b0;
      end else if (s1_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            exp_out    <= s1_exp;
            mant_big   <= s1_big;
            mant_small <= sh_mant;
            grs        <= sh_grs;
            swapped    <= s1_swapped;
         end
      end
   end

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed cases, back-pressure,
// mid-stall reset and a randomized run against an arithmetic reference model.
module tb_fp_align_stage;

   typedef struct packed {
      logic [7:0]  exp_a;
      logic [7:0]  exp_b;
      logic [23:0] mant_a;
      logic [23:0] mant_b;
      logic [4:0]  ns;
      logic        sign;
   } stim_t;

   typedef struct {
      logic [7:0]  exp;
      logic [23:0] big;
      logic [23:0] sm;
      logic [2:0]  grs;
      logic        swapped;
      int          acc_edge;
   } expect_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic [23:0] mant_a;
   logic [23:0] mant_b;
   logic [4:0]  numbershift;
   logic        sign;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  exp_out;
   logic [23:0] mant_big;
   logic [23:0] mant_small;
   logic [2:0]  grs;
   logic        swapped;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   expect_t exp_q[$];

   fp_align_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .exp_a       (exp_a),
      .exp_b       (exp_b),
      .mant_a      (mant_a),
      .mant_b      (mant_b),
      .numbershift (numbershift),
      .sign        (sign),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .exp_out     (exp_out),
      .mant_big    (mant_big),
      .mant_small  (mant_small),
      .grs         (grs),
      .swapped     (swapped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: pick the larger exponent, then shift with plain integer arithmetic.
   function automatic expect_t model(input stim_t s, input int acc_edge);
      expect_t m;
      int      eb, es, d, ns;
      longint  mb, msm;
      logic    g, r, st;
      if (s.sign) begin
         eb = int'(s.exp_b); es = int'(s.exp_a);
         mb = longint'(s.mant_b); msm = longint'(s.mant_a);
      end else begin
         eb = int'(s.exp_a); es = int'(s.exp_b);
         mb = longint'(s.mant_a); msm = longint'(s.mant_b);
      end
      d  = (eb - es + 512) % 512;
      ns = int'(s.ns);
      m.exp      = 8'(eb);
      m.big      = 24'(mb);
      m.swapped  = s.sign;
      m.acc_edge = acc_edge;
      if (d >= 24) begin
         m.sm  = 24'd0;
         m.grs = {2'b00, msm != 0};
      end else begin
         m.sm  = 24'(msm >> ns);
         g  = (ns >= 1) ? (((msm >> (ns - 1)) & 1) != 0) : 1'b0;
         r  = (ns >= 2) ? (((msm >> (ns - 2)) & 1) != 0) : 1'b0;
         st = (ns >= 3) ? ((msm & ((64'd1 << (ns - 2)) - 1)) != 0) : 1'b0;
         m.grs = {g, r, st};
      end
      return m;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      int eb, es, d, sel;
      logic [23:0] mbig, msml;
      eb   = int'($urandom_range(254, 61));
      sel  = int'($urandom_range(3, 0));
      d    = (sel < 2) ? int'($urandom_range(23, 0)) :
             (sel == 2) ? int'($urandom_range(60, 24)) : 0;
      es   = eb - d;
      mbig = {1'b1, 23'($urandom)};
      msml = {1'b1, 23'($urandom)};
      if (d == 0 || $urandom_range(1, 0) == 0) begin
         s.exp_a = 8'(eb); s.exp_b = 8'(es); s.mant_a = mbig; s.mant_b = msml; s.sign = 1'b0;
      end else begin
         s.exp_a = 8'(es); s.exp_b = 8'(eb); s.mant_a = msml; s.mant_b = mbig; s.sign = 1'b1;
      end
      s.ns = (d < 24) ? 5'(d) : 5'd0;
      return s;
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput();
      checkValue("exp_out",    32'(exp_out),    32'(exp_q[0].exp));
      checkValue("mant_big",   32'(mant_big),   32'(exp_q[0].big));
      checkValue("mant_small", 32'(mant_small), 32'(exp_q[0].sm));
      checkValue("grs",        32'(grs),        32'(exp_q[0].grs));
      checkValue("swapped",    32'(swapped),    32'(exp_q[0].swapped));
   endtask

   // One clock cycle: drive, check handshake and outputs, update the model, advance.
   task automatic applyStimulus(input logic v, input stim_t s, input logic ordy, output logic accepted);
      logic vis;
      in_valid    = v;
      exp_a       = s.exp_a;
      exp_b       = s.exp_b;
      mant_a      = s.mant_a;
      mant_b      = s.mant_b;
      numbershift = s.ns;
      sign        = s.sign;
      out_ready   = ordy;
      #1;
      checkValue("in_ready", 32'(in_ready), 32'(exp_q.size() < 2 || ordy));
      vis = exp_q.size() > 0 && cyc >= exp_q[0].acc_edge + 1;
      checkValue("out_valid", 32'(out_valid), 32'(vis));
      if (vis) checkOutput();
      if (vis && ordy) void'(exp_q.pop_front());
      accepted = v && in_ready;
      if (accepted) exp_q.push_back(model(s, cyc + 1));
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic directed(input string tag, input stim_t s, input logic [7:0] e_exp,
                           input logic [23:0] e_big, input logic [23:0] e_sm,
                           input logic [2:0] e_grs, input logic e_sw);
      logic acc;
      applyStimulus(1'b1, s, 1'b1, acc);
      checkValue({tag, "_accept"}, 32'(acc), 32'd1);
      applyStimulus(1'b0, '0, 1'b1, acc);
      checkValue({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkValue({tag, "_exp"},   32'(exp_out),    32'(e_exp));
      checkValue({tag, "_big"},   32'(mant_big),   32'(e_big));
      checkValue({tag, "_small"}, 32'(mant_small), 32'(e_sm));
      checkValue({tag, "_grs"},   32'(grs),        32'(e_grs));
      checkValue({tag, "_swap"},  32'(swapped),    32'(e_sw));
      applyStimulus(1'b0, '0, 1'b1, acc);
   endtask

   initial begin
      stim_t vec[4];
      stim_t cur;
      logic  acc;
      int    idx;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      exp_a = '0; exp_b = '0; mant_a = '0; mant_b = '0; numbershift = '0; sign = 1'b0;
      #2;
      checkValue("rst_in_ready",   32'(in_ready),   32'd0);
      checkValue("rst_out_valid",  32'(out_valid),  32'd0);
      checkValue("rst_exp_out",    32'(exp_out),    32'd0);
      checkValue("rst_mant_big",   32'(mant_big),   32'd0);
      checkValue("rst_mant_small", 32'(mant_small), 32'd0);
      checkValue("rst_grs",        32'(grs),        32'd0);
      checkValue("rst_swapped",    32'(swapped),    32'd0);
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;

      $display("[TB] directed vectors");
      directed("near1", '{8'd127, 8'd126, 24'h800000, 24'h800000, 5'd1, 1'b0},
               8'd127, 24'h800000, 24'h400000, 3'b000, 1'b0);
      directed("swap2", '{8'd125, 8'd127, 24'h800003, 24'hC00000, 5'd2, 1'b1},
               8'd127, 24'hC00000, 24'h200000, 3'b110, 1'b1);
      directed("far",   '{8'd150, 8'd100, 24'h800000, 24'h800001, 5'd0, 1'b0},
               8'd150, 24'h800000, 24'h000000, 3'b001, 1'b0);
      directed("equal", '{8'd127, 8'd127, 24'hA00000, 24'hF00001, 5'd0, 1'b0},
               8'd127, 24'hA00000, 24'hF00001, 3'b000, 1'b0);

      $display("[TB] back-pressure");
      for (int i = 0; i < 4; i++) vec[i] = rand_stim();
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(idx < 4, (idx < 4) ? vec[idx] : stim_t'('0), 1'b0, acc);
         if (acc) idx++;
      end
      checkValue("stall_accepts", 32'(idx), 32'd2);
      for (int c = 0; c < 20 && (idx < 4 || exp_q.size() > 0); c++) begin
         applyStimulus(idx < 4, (idx < 4) ? vec[idx] : stim_t'('0), 1'b1, acc);
         if (acc) idx++;
      end
      checkValue("stall_drain", 32'(exp_q.size() + (4 - idx)), 32'd0);

      $display("[TB] reset with full pipeline");
      applyStimulus(1'b1, rand_stim(), 1'b0, acc);
      applyStimulus(1'b1, rand_stim(), 1'b0, acc);
      checkValue("full_in_ready", 32'(in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      checkValue("arst_out_valid",  32'(out_valid),  32'd0);
      checkValue("arst_exp_out",    32'(exp_out),    32'd0);
      checkValue("arst_mant_big",   32'(mant_big),   32'd0);
      checkValue("arst_mant_small", 32'(mant_small), 32'd0);
      checkValue("arst_grs",        32'(grs),        32'd0);
      checkValue("arst_swapped",    32'(swapped),    32'd0);
      checkValue("arst_in_ready",   32'(in_ready),   32'd0);
      exp_q.delete();
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, rand_stim(), 1'b1, acc);
      checkValue("post_rst_accept", 32'(acc), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, acc);
      checkValue("post_rst_latency", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, '0, 1'b1, acc);

      $display("[TB] randomized traffic");
      cur = rand_stim();
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(9, 0) < 7, cur, $urandom_range(9, 0) < 7, acc);
         if (acc) cur = rand_stim();
      end
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) applyStimulus(1'b0, '0, 1'b1, acc);
      checkValue("final_drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
